// File: rtl/program_loader.sv
// Program loader: captures opcodes entered on board switches, one per
// debounced strobe press, into a program RAM. It also provides the
// asynchronous fetch port used by the CPU, and holds the CPU in reset
// while a program is being entered.
module program_loader #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 4
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  load_req_i,
  input  logic                  run_req_i,
  input  logic                  strobe_i,
  input  logic [DATA_WIDTH-1:0] data_in_i,
  input  logic [ADDR_WIDTH-1:0] read_addr_i,
  output logic [DATA_WIDTH-1:0] read_data_o,
  output logic                  cpu_hold_o,
  output logic [ADDR_WIDTH-1:0] wr_addr_o,
  output logic [ADDR_WIDTH:0]   word_count_o,
  output logic                  loading_o
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = {ADDR_WIDTH{1'b1}};
  localparam logic [ADDR_WIDTH:0]   CNT_ZERO  = {(ADDR_WIDTH+1){1'b0}};
  localparam logic [ADDR_WIDTH:0]   CNT_ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0]   CNT_FULL  = {1'b1, {ADDR_WIDTH{1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_LOAD    = 2'b01,
    ST_RUN     = 2'b10,
    ST_ILLEGAL = 2'b11
  } state_e;

  // Synchroniser chains, bit 0 = loadReq, bit 1 = runReq, bit 2 = strobe.
  logic [2:0] sync1_q;
  logic [2:0] sync2_q;
  logic [2:0] sync3_q;
  logic [2:0] rise_s;

  logic load_rise_s;
  logic run_rise_s;
  logic strobe_rise_s;
  logic load_level_s;

  state_e                state_q;
  state_e                state_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q;
  logic [ADDR_WIDTH-1:0] wr_addr_d;
  logic [ADDR_WIDTH:0]   word_count_q;
  logic [ADDR_WIDTH:0]   word_count_d;
  logic                  cpu_hold_q;
  logic                  cpu_hold_d;
  logic                  loading_q;
  logic                  loading_d;
  logic                  mem_we_s;

  // Program storage; deliberately not reset so a reset keeps the loaded program.
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  assign rise_s        = sync2_q & ~sync3_q;
  assign load_rise_s   = rise_s[0];
  assign run_rise_s    = rise_s[1];
  assign strobe_rise_s = rise_s[2];
  assign load_level_s  = sync2_q[0];

  // Two-flop synchronisers plus an edge-history flop for each async input.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync1_q <= 3'b000;
      sync2_q <= 3'b000;
      sync3_q <= 3'b000;
    end else begin
      sync1_q <= {strobe_i, run_req_i, load_req_i};
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  // Next-state, write-pointer and word-count logic for the load sessions.
  always_comb begin
    state_d      = state_q;
    wr_addr_d    = wr_addr_q;
    word_count_d = word_count_q;
    mem_we_s     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (load_rise_s) begin
          state_d      = ST_LOAD;
          wr_addr_d    = ADDR_ZERO;
          word_count_d = CNT_ZERO;
        end else if (run_rise_s) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (strobe_rise_s) begin
          mem_we_s  = 1'b1;
          wr_addr_d = wr_addr_q + ADDR_ONE;
          if (word_count_q != CNT_FULL) begin
            word_count_d = word_count_q + CNT_ONE;
          end else begin
            word_count_d = word_count_q;
          end
        end else begin
          mem_we_s = 1'b0;
        end
        // Filling the last word or dropping the load switch both hand over to the CPU;
        // a strobe in the exit cycle has already been written above.
        if ((strobe_rise_s && (wr_addr_q == ADDR_LAST)) || !load_level_s) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_LOAD;
        end
      end
      ST_RUN: begin
        if (load_rise_s) begin
          state_d      = ST_LOAD;
          wr_addr_d    = ADDR_ZERO;
          word_count_d = CNT_ZERO;
        end else begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    cpu_hold_d = (state_d != ST_RUN);
    loading_d  = (state_d == ST_LOAD);
  end

  // Controller registers; the status outputs follow the next state so they
  // change on the same edge as the state itself.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= ST_IDLE;
      wr_addr_q    <= ADDR_ZERO;
      word_count_q <= CNT_ZERO;
      cpu_hold_q   <= 1'b1;
      loading_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_addr_q    <= wr_addr_d;
      word_count_q <= word_count_d;
      cpu_hold_q   <= cpu_hold_d;
      loading_q    <= loading_d;
    end
  end

  // Program RAM write port; data is taken at the same edge as the write.
  always_ff @(posedge clk_i) begin
    if (mem_we_s && !reset_i) begin
      mem_q[wr_addr_q] <= data_in_i;
    end
  end

  assign read_data_o  = mem_q[read_addr_i];
  assign cpu_hold_o   = cpu_hold_q;
  assign loading_o    = loading_q;
  assign wr_addr_o    = wr_addr_q;
  assign word_count_o = word_count_q;

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: stimulus tasks update a behavioural
// model of the loader and queue expected observations; a monitor on the
// falling clock edge pops and compares them against the DUT.
module tb_program_loader;

  localparam int AW    = 8;
  localparam int DW    = 4;
  localparam int DEPTH = 256;

  logic          clk = 1'b0;
  logic          reset;
  logic          load_req;
  logic          run_req;
  logic          strobe;
  logic [DW-1:0] data_in;
  logic [AW-1:0] read_addr;
  logic [DW-1:0] read_data;
  logic          cpu_hold;
  logic [AW-1:0] wr_addr;
  logic [AW:0]   word_count;
  logic          loading;

  program_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .load_req_i   (load_req),
    .run_req_i    (run_req),
    .strobe_i     (strobe),
    .data_in_i    (data_in),
    .read_addr_i  (read_addr),
    .read_data_o  (read_data),
    .cpu_hold_o   (cpu_hold),
    .wr_addr_o    (wr_addr),
    .word_count_o (word_count),
    .loading_o    (loading)
  );

  always #5 clk = ~clk;

  // Behavioural model: mode 0 = idle, 1 = loading, 2 = CPU running.
  logic [DW-1:0] m_mem [DEPTH];
  int            m_mode;
  int            m_addr;
  int            m_count;

  typedef struct {
    int    kind;
    int    exp;
    string name;
  } chk_t;

  chk_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  // Monitor: compare every queued expectation against the DUT while it is stable.
  always @(negedge clk) begin
    while (sb.size() > 0) begin
      chk_t c;
      int   act;
      c = sb.pop_front();
      case (c.kind)
        0:       act = int'(cpu_hold);
        1:       act = int'(loading);
        2:       act = int'(wr_addr);
        3:       act = int'(word_count);
        4:       act = int'(read_data);
        default: act = -1;
      endcase
      checks++;
      if (act !== c.exp) begin
        failures++;
        $display("FAIL %s: got %0d expected %0d", c.name, act, c.exp);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input int kind, input int exp, input string name);
    chk_t c;
    c.kind = kind;
    c.exp  = exp;
    c.name = name;
    sb.push_back(c);
  endtask

  task automatic expect_status(input string tag);
    push(0, (m_mode != 2) ? 1 : 0, {tag, ".cpu_hold"});
    push(1, (m_mode == 1) ? 1 : 0, {tag, ".loading"});
    push(2, m_addr, {tag, ".wr_addr"});
    push(3, m_count, {tag, ".word_count"});
    tick(1);
  endtask

  task automatic expect_read(input int a, input string tag);
    read_addr = a[AW-1:0];
    push(4, int'(m_mem[a]), $sformatf("%s.read[%0d]", tag, a));
    tick(1);
  endtask

  task automatic press_strobe(input logic [DW-1:0] d, input int hold);
    data_in = d;
    strobe  = 1'b1;
    tick(hold);
    strobe  = 1'b0;
    tick(3);
    if (m_mode == 1) begin
      m_mem[m_addr] = d;
      if (m_addr == DEPTH - 1) m_mode = 2;
      m_addr = (m_addr + 1) % DEPTH;
      if (m_count < DEPTH) m_count++;
    end
  endtask

  task automatic set_load(input logic v);
    logic prev;
    prev     = load_req;
    load_req = v;
    tick(4);
    if (v && !prev && m_mode != 1) begin
      m_mode  = 1;
      m_addr  = 0;
      m_count = 0;
    end else if (!v && m_mode == 1) begin
      m_mode = 2;
    end
  endtask

  task automatic pulse_run();
    run_req = 1'b1;
    tick(4);
    run_req = 1'b0;
    tick(3);
    if (m_mode == 0) m_mode = 2;
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    load_req = 1'b0;
    run_req  = 1'b0;
    strobe   = 1'b0;
    tick(3);
    reset    = 1'b0;
    tick(1);
    m_mode  = 0;
    m_addr  = 0;
    m_count = 0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    load_req  = 1'b0;
    run_req   = 1'b0;
    strobe    = 1'b0;
    data_in   = 4'h0;
    read_addr = 8'h00;
    m_mode    = 0;
    m_addr    = 0;
    m_count   = 0;
    tick(1);
    do_reset();
    expect_status("reset");

    // Load request: still idle after two edges, loading on the third.
    load_req = 1'b1;
    tick(2);
    push(1, 0, "load_lat.loading_early");
    push(0, 1, "load_lat.hold_early");
    tick(1);
    push(1, 1, "load_lat.loading");
    push(0, 1, "load_lat.hold");
    push(2, 0, "load_lat.wr_addr");
    m_mode  = 1;
    m_addr  = 0;
    m_count = 0;
    tick(1);

    press_strobe(4'h3, $urandom_range(1, 3));
    press_strobe(4'hA, $urandom_range(1, 3));
    press_strobe(4'hF, $urandom_range(1, 3));
    expect_status("three_writes");
    press_strobe(4'($urandom_range(0, 15)), 20);
    expect_status("long_press");
    for (int i = 0; i < int'($urandom_range(1, 4)); i++) begin
      press_strobe(4'($urandom_range(0, 15)), $urandom_range(1, 4));
    end
    set_load(1'b0);
    expect_status("load_exit");
    expect_read(1, "load_exit");
    for (int i = 0; i < m_addr; i++) expect_read(i, "session1");

    // Strobe while the CPU runs must not write.
    press_strobe(4'($urandom_range(0, 15)), 2);
    expect_status("run_strobe");
    for (int i = 0; i < m_addr + 1 && i < 6; i++) begin
      if (i < m_count) expect_read(i, "run_strobe");
    end

    // Fill the whole memory; auto-exit to run on the last word.
    set_load(1'b1);
    expect_status("full_start");
    for (int i = 0; i < DEPTH; i++) press_strobe(4'(i % 16), 1);
    expect_status("full_done");
    expect_read(255, "full");
    for (int i = 0; i < 6; i++) expect_read($urandom_range(0, DEPTH - 1), "full_rand");
    tick(10);
    expect_status("full_no_restart");
    set_load(1'b0);
    set_load(1'b1);
    expect_status("new_session");

    // Reset in the middle of a session keeps the words written so far.
    press_strobe(4'($urandom_range(0, 15)), 1);
    press_strobe(4'($urandom_range(0, 15)), 2);
    expect_status("before_reset");
    do_reset();
    expect_status("mid_reset");
    expect_read(0, "mid_reset");
    expect_read(1, "mid_reset");

    // Run request from idle releases the CPU.
    pulse_run();
    expect_status("run_from_idle");
    do_reset();

    // Simultaneous load and run requests from idle: load wins.
    load_req = 1'b1;
    run_req  = 1'b1;
    tick(4);
    run_req  = 1'b0;
    tick(3);
    m_mode  = 1;
    m_addr  = 0;
    m_count = 0;
    expect_status("both_req");
    set_load(1'b0);
    expect_status("both_exit");

    tick(2);
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left, expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
